imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. Accepts one instruction word per cycle over a valid/ready handshake. Decodes the format and produces the sign- or zero-extended immediate at XLEN width. Results are registered through a 2-entry skid buffer so that backpressure from execute never drops or reorders instructions. It also reports the decoded format, flags illegal opcodes and counts them.

Parameters:
XLEN, 32, output immediate width; legal values 32 or 64.
CNT_W, 16, width of the saturating illegal-opcode counter.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction word present
in_ready  output  1  block can accept a word this cycle
in_inst  input  32  instruction word
out_valid  output  1  result present
out_ready  input  1  consumer accepts the result this cycle
out_imm  output  XLEN  decoded immediate
out_fmt  output  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR uimm)
out_illegal  output  1  opcode not recognised
out_inst  output  32  instruction word passed through, aligned with out_imm
illegal_cnt  output  CNT_W  saturating count of accepted illegal words

Behaviour:
- Interface: one clock (clk); reset rst_n is synchronous, active-low.
- Reset values:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_inst=0, illegal_cnt=0.
  - Skid entry invalid; in_ready=1 in the first cycle after reset is released.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_* data holds stable while out_valid & !out_ready.
- Latency: 1 cycle. A word accepted at edge N appears on out_* after edge N when the output register is empty or draining.
- Buffer: output register plus one skid entry; in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Accept while output full and not draining: word goes to skid.
  - Drain with skid valid: skid moves to output; a same-cycle accept is impossible, since in_ready=0.
  - Accept and drain in the same cycle with skid empty: new word replaces output.
  - Order is always preserved.
- Decode by in_inst[6:0], decoded before registering. imm is sign-extended from inst[31] to XLEN unless stated otherwise.
  - 0000011 load, 1100111 JALR: I, imm = inst[31:20].
  - 0010011 OP-IMM: I, imm = inst[31:20]. Exception: funct3 001/101 gives a zero-extended shamt, inst[24:20] when XLEN=32 and inst[25:20] when XLEN=64.
  - 0100011: S, imm = {inst[31:25], inst[11:7]}.
  - 1100011: B, imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 1101111: J, imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 0110111 LUI, 0010111 AUIPC: U, imm = {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - 0110011 OP, 0001111 FENCE: fmt=0, imm=0, legal.
  - 1110011 SYSTEM: fmt=0, imm=0, legal (see Optional Feature).
  - Any other opcode: fmt=0, imm=0, out_illegal=1.
- illegal_cnt:
  - Increments on input transfer of an illegal word.
  - Saturates at all-ones and does not wrap.
  - Counts at acceptance, not at output.
- Reset mid-operation: both buffer entries are invalidated, all outputs return to reset values and in-flight words are discarded.

Optional Feature:
IMM_GEN_ZICSR_EN.
- Defined: SYSTEM opcode with funct3 in {101,110,111} gives fmt=6 (Z) and imm = zero-extended inst[19:15]. Other SYSTEM words remain fmt=0, imm=0, legal.
- Undefined: fmt value 6 is never produced and every SYSTEM word gives fmt=0, imm=0.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=1, illegal=0.
- SW x1,-4(x2) (0xFE112E23) -> imm=0xFFFFFFFC, fmt=2.
- JAL 0x800000EF -> imm=0xFFF00000, fmt=5. AUIPC 0x12345017 -> imm=0x12345000, fmt=4. SRAI 0x4051D093 -> imm=0x00000005.
- Backpressure: hold out_ready=0 and drive 3 back-to-back words A,B,C -> A and B accepted, in_ready=0 from the cycle after B is accepted, C stalls. Then raise out_ready -> A,B,C emerge in order with no loss and out_imm stable while stalled.
- Illegal 0x0000007F ×3 -> out_illegal=1, imm=0, illegal_cnt=3. With CNT_W=2, 5 illegal words -> count stays 3.
- rst_n=0 for one cycle while out_valid=1 and skid full -> next cycle out_valid=0, in_ready=1, illegal_cnt=0, and no stale word is emitted afterwards.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
// ------------
// Decode-stage immediate generator with a 1-cycle pipeline and a 2-entry
// output buffer (output register + skid entry).
//
// Instruction words arrive on a valid/ready handshake. Each word is decoded
// combinationally by opcode. The immediate is sign- or zero-extended to XLEN,
// and the result is registered together with the format code, an illegal
// flag and the original word. If execute stalls, one extra word can still be
// accepted into the skid entry, so words are never dropped or reordered.
// in_ready comes straight from a flop and has no combinational path from
// out_ready.
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   CNT_W  width of the saturating illegal-opcode counter
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   in_valid     instruction word present
//   in_ready     block can accept a word this cycle
//   in_inst      32-bit instruction word
//   out_valid    result present
//   out_ready    consumer accepts the result this cycle
//   out_imm      decoded immediate (XLEN bits)
//   out_fmt      0=none 1=I 2=S 3=B 4=U 5=J 6=Z (CSR uimm)
//   out_illegal  opcode not recognised
//   out_inst     instruction word aligned with out_imm
//   illegal_cnt  saturating count of accepted illegal words
//
// Optional feature
//   IMM_GEN_ZICSR_EN  when defined, the SYSTEM funct3 values 101/110/111 decode
//                     as format Z with imm = zero-extended inst[19:15].
//                     When undefined, format 6 is never produced.

module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [31:0]      out_inst,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Decoder outputs for the word currently on in_inst
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     dec_imm32;
  logic            dec_zext;
  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;

  // Output register
  logic            out_valid_q,   out_valid_d;
  logic [XLEN-1:0] out_imm_q,     out_imm_d;
  fmt_e            out_fmt_q,     out_fmt_d;
  logic            out_illegal_q, out_illegal_d;
  logic [31:0]     out_inst_q,    out_inst_d;

  // Skid entry
  logic            skid_valid_q,   skid_valid_d;
  logic [XLEN-1:0] skid_imm_q,     skid_imm_d;
  fmt_e            skid_fmt_q,     skid_fmt_d;
  logic            skid_illegal_q, skid_illegal_d;
  logic [31:0]     skid_inst_q,    skid_inst_d;

  // Illegal-opcode counter
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  logic in_fire;
  logic out_fire;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];

  // The opcode decoder first builds a 32-bit immediate plus a flag that says
  // whether it must be zero-extended (shift amounts, CSR uimm). The widening
  // to XLEN is done in one place below. That keeps every format expression
  // independent of XLEN.
  always_comb begin
    dec_imm32   = '0;
    dec_zext    = 1'b0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OPC_OP_IMM: begin
        dec_fmt = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift-immediate: the field above shamt is funct7, not immediate
          dec_zext = 1'b1;
          if (XLEN == 64) begin
            dec_imm32 = {26'b0, in_inst[25:20]};
          end else begin
            dec_imm32 = {27'b0, in_inst[24:20]};
          end
        end else begin
          dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      OPC_STORE: begin
        dec_fmt   = FMT_S;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt   = FMT_B;
        dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec_fmt   = FMT_J;
        dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt   = FMT_U;
        dec_imm32 = {in_inst[31:12], 12'b0};
      end
      OPC_OP, OPC_FENCE: begin
        dec_fmt = FMT_NONE;
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          dec_fmt   = FMT_Z;
          dec_zext  = 1'b1;
          dec_imm32 = {27'b0, in_inst[19:15]};
        end
`else
        // Without CSR support every SYSTEM word is legal with no immediate
        dec_fmt = FMT_NONE;
`endif
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Widen the 32-bit immediate to XLEN. The low word is copied as is and the
  // upper bits are filled with either zero or bit 31. For XLEN=32 the fill is
  // fully overwritten.
  always_comb begin
    dec_imm = dec_zext ? '0 : {XLEN{dec_imm32[31]}};
    dec_imm[31:0] = dec_imm32;
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // Buffer control. The skid entry only fills when the output register is
  // occupied and not draining. While it is full, in_ready is low, so on a
  // drain the skid word moves to the output and nothing new can arrive that
  // cycle. Output data is only written when a new word is loaded, so it
  // holds steady under backpressure.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    out_inst_d     = out_inst_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;
    skid_inst_d    = skid_inst_q;

    if (skid_valid_q) begin
      if (out_fire) begin
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        out_inst_d    = skid_inst_q;
        skid_valid_d  = 1'b0;
      end
    end else if (in_fire) begin
      if (!out_valid_q || out_fire) begin
        out_valid_d   = 1'b1;
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
        out_inst_d    = in_inst;
      end else begin
        skid_valid_d   = 1'b1;
        skid_imm_d     = dec_imm;
        skid_fmt_d     = dec_fmt;
        skid_illegal_d = dec_illegal;
        skid_inst_d    = in_inst;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  // Illegal words are counted when they are accepted, not when they leave the
  // block. The counter sticks at all-ones instead of wrapping.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (in_fire && dec_illegal && (illegal_cnt_q != {CNT_W{1'b1}})) begin
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end
  end

  // State registers. Reset clears both buffer entries, so words that are in
  // flight are discarded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      out_inst_q     <= '0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
      skid_inst_q    <= '0;
      illegal_cnt_q  <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      out_inst_q     <= out_inst_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
      skid_inst_q    <= skid_inst_d;
      illegal_cnt_q  <= illegal_cnt_d;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign out_inst    = out_inst_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe
// ---------------
// Directed testbench for imm_gen_pipe. Three copies of the design share the
// same inputs:
//   dut     XLEN=32, CNT_W=16 (main checks)
//   dut_sat XLEN=32, CNT_W=2  (counter saturation)
//   dut64   XLEN=64, CNT_W=16 (upper-half extension and 6-bit shamt)
// Expected immediates are worked out by hand from the instruction encodings.
// When IMM_GEN_ZICSR_EN is defined, the CSR vector expects format Z.

module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        in_ready,    s_in_ready,    w_in_ready;
  logic        out_valid,   s_out_valid,   w_out_valid;
  logic [31:0] out_imm,     s_out_imm;
  logic [63:0] w_out_imm;
  logic [2:0]  out_fmt,     s_out_fmt,     w_out_fmt;
  logic        out_illegal, s_out_illegal, w_out_illegal;
  logic [31:0] out_inst,    s_out_inst,    w_out_inst;
  logic [15:0] illegal_cnt, w_illegal_cnt;
  logic [1:0]  s_illegal_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
  } vec_t;

  vec_t vecs[$];

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_inst(out_inst),
    .illegal_cnt(illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_inst(in_inst),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_imm(s_out_imm),
    .out_fmt(s_out_fmt), .out_illegal(s_out_illegal), .out_inst(s_out_inst),
    .illegal_cnt(s_illegal_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_inst(in_inst),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_imm(w_out_imm),
    .out_fmt(w_out_fmt), .out_illegal(w_out_illegal), .out_inst(w_out_inst),
    .illegal_cnt(w_illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a failure line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one word for exactly one edge, then leave inputs idle and sample
  // 1 time unit after that edge
  task automatic applyStimulus(input logic [31:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_inst   = '0;
    out_ready = 1'b1;
    rst_n     = 1'b0;

    vecs.push_back('{"addi_neg1",  32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1});
    vecs.push_back('{"sw_neg4",    32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2});
    vecs.push_back('{"jal",        32'h800000EF, 32'hFFF00000, 64'hFFFFFFFF_FFF00000, 3'd5});
    vecs.push_back('{"auipc",      32'h12345017, 32'h12345000, 64'h00000000_12345000, 3'd4});
    vecs.push_back('{"srai5",      32'h4051D093, 32'h00000005, 64'h00000000_00000005, 3'd1});
    vecs.push_back('{"lui_msb",    32'h800000B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4});
    vecs.push_back('{"lw_neg8",    32'hFF812083, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd1});
    vecs.push_back('{"jalr_max",   32'h7FF08067, 32'h000007FF, 64'h00000000_000007FF, 3'd1});
    vecs.push_back('{"beq_neg4",   32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3});
    vecs.push_back('{"beq_pos16",  32'h00000863, 32'h00000010, 64'h00000000_00000010, 3'd3});
    vecs.push_back('{"slli_b25",   32'h03F09093, 32'h0000001F, 64'h00000000_0000003F, 3'd1});
    vecs.push_back('{"srli_zext",  32'hFFF0D093, 32'h0000001F, 64'h00000000_0000003F, 3'd1});
    vecs.push_back('{"add",        32'h002081B3, 32'h00000000, 64'h0,                 3'd0});
    vecs.push_back('{"fence",      32'h0FF0000F, 32'h00000000, 64'h0,                 3'd0});
    vecs.push_back('{"ecall",      32'h00000073, 32'h00000000, 64'h0,                 3'd0});
    vecs.push_back('{"csrrw",      32'h34029073, 32'h00000000, 64'h0,                 3'd0});
`ifdef IMM_GEN_ZICSR_EN
    vecs.push_back('{"csrrwi",     32'h340FD073, 32'h0000001F, 64'h00000000_0000001F, 3'd6});
`else
    vecs.push_back('{"csrrwi",     32'h340FD073, 32'h00000000, 64'h0,                 3'd0});
`endif

    // Reset state
    idleCycle();
    idleCycle();
    rst_n = 1'b1;
    checkOutput("rst out_valid",   {63'b0, out_valid},   64'd0);
    checkOutput("rst in_ready",    {63'b0, in_ready},    64'd1);
    checkOutput("rst out_imm",     {32'b0, out_imm},     64'd0);
    checkOutput("rst out_fmt",     {61'b0, out_fmt},     64'd0);
    checkOutput("rst out_illegal", {63'b0, out_illegal}, 64'd0);
    checkOutput("rst out_inst",    {32'b0, out_inst},    64'd0);
    checkOutput("rst illegal_cnt", {48'b0, illegal_cnt}, 64'd0);

    // Table: back-to-back words, consumer always ready
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].inst);
      checkOutput({vecs[i].name, " valid"},   {63'b0, out_valid},   64'd1);
      checkOutput({vecs[i].name, " inst"},    {32'b0, out_inst},    {32'b0, vecs[i].inst});
      checkOutput({vecs[i].name, " imm32"},   {32'b0, out_imm},     {32'b0, vecs[i].imm32});
      checkOutput({vecs[i].name, " imm64"},   w_out_imm,            vecs[i].imm64);
      checkOutput({vecs[i].name, " fmt"},     {61'b0, out_fmt},     {61'b0, vecs[i].fmt});
      checkOutput({vecs[i].name, " fmt64"},   {61'b0, w_out_fmt},   {61'b0, vecs[i].fmt});
      checkOutput({vecs[i].name, " illegal"}, {63'b0, out_illegal}, 64'd0);
      checkOutput({vecs[i].name, " ready"},   {63'b0, in_ready},    64'd1);
    end
    checkOutput("legal words not counted", {48'b0, illegal_cnt}, 64'd0);
    idleCycle();
    checkOutput("drain after table", {63'b0, out_valid}, 64'd0);

    // Illegal words: counted at acceptance, saturating in the 2-bit copy
    for (int k = 0; k < 3; k++) begin
      applyStimulus(32'h0000007F);
      checkOutput($sformatf("ill%0d illegal", k), {63'b0, out_illegal}, 64'd1);
      checkOutput($sformatf("ill%0d imm", k),     {32'b0, out_imm},     64'd0);
      checkOutput($sformatf("ill%0d fmt", k),     {61'b0, out_fmt},     64'd0);
      checkOutput($sformatf("ill%0d cnt", k),     {48'b0, illegal_cnt}, k + 1);
    end
    checkOutput("sat cnt at 3", {62'b0, s_illegal_cnt}, 64'd3);
    applyStimulus(32'h00000000);
    applyStimulus(32'h0000000B);
    checkOutput("cnt after 5",      {48'b0, illegal_cnt},   64'd5);
    checkOutput("cnt64 after 5",    {48'b0, w_illegal_cnt}, 64'd5);
    checkOutput("sat cnt stays 3",  {62'b0, s_illegal_cnt}, 64'd3);
    checkOutput("last ill illegal", {63'b0, out_illegal},   64'd1);
    idleCycle();

    // Backpressure: A into output, B into skid, C stalls, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    idleCycle();
    checkOutput("bp A valid", {63'b0, out_valid}, 64'd1);
    checkOutput("bp A inst",  {32'b0, out_inst},  64'hFFF00093);
    checkOutput("bp ready after A", {63'b0, in_ready}, 64'd1);
    in_inst = 32'hFE112E23;
    idleCycle();
    checkOutput("bp ready after B", {63'b0, in_ready}, 64'd0);
    checkOutput("bp hold inst 1",   {32'b0, out_inst}, 64'hFFF00093);
    checkOutput("bp hold imm 1",    {32'b0, out_imm},  64'hFFFFFFFF);
    in_inst = 32'h800000EF;
    idleCycle();
    checkOutput("bp C stalled ready", {63'b0, in_ready}, 64'd0);
    checkOutput("bp hold inst 2",     {32'b0, out_inst}, 64'hFFF00093);
    checkOutput("bp hold imm 2",      {32'b0, out_imm},  64'hFFFFFFFF);
    out_ready = 1'b1;
    idleCycle();
    checkOutput("bp B inst",  {32'b0, out_inst}, 64'hFE112E23);
    checkOutput("bp B imm",   {32'b0, out_imm},  64'hFFFFFFFC);
    checkOutput("bp B fmt",   {61'b0, out_fmt},  64'd2);
    checkOutput("bp ready after skid drain", {63'b0, in_ready}, 64'd1);
    idleCycle();
    in_valid = 1'b0;
    checkOutput("bp C inst",  {32'b0, out_inst}, 64'h800000EF);
    checkOutput("bp C imm",   {32'b0, out_imm},  64'hFFF00000);
    checkOutput("bp C valid", {63'b0, out_valid}, 64'd1);
    idleCycle();
    checkOutput("bp drained", {63'b0, out_valid}, 64'd0);

    // Reset while output and skid are both full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h0000007F;
    idleCycle();
    in_inst = 32'hFFF00093;
    idleCycle();
    in_valid = 1'b0;
    checkOutput("pre-rst skid full", {63'b0, in_ready},  64'd0);
    checkOutput("pre-rst out valid", {63'b0, out_valid}, 64'd1);
    checkOutput("pre-rst cnt",       {48'b0, illegal_cnt}, 64'd6);
    rst_n = 1'b0;
    idleCycle();
    rst_n = 1'b1;
    checkOutput("mid-rst out_valid", {63'b0, out_valid},     64'd0);
    checkOutput("mid-rst in_ready",  {63'b0, in_ready},      64'd1);
    checkOutput("mid-rst cnt",       {48'b0, illegal_cnt},   64'd0);
    checkOutput("mid-rst sat cnt",   {62'b0, s_illegal_cnt}, 64'd0);
    checkOutput("mid-rst out_inst",  {32'b0, out_inst},      64'd0);
    checkOutput("mid-rst out_imm",   {32'b0, out_imm},       64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idleCycle();
      checkOutput($sformatf("no stale word %0d", k), {63'b0, out_valid}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
